ewrapper_rx_deser: RTL and testbench

EWRAPPER_RX_DESER -- requirements
Module: ewrapper_rx_deser

---
 rtl/ewrapper_rx_deser.sv | 99 +++++++++
 tb/tb_ewrapper_rx_deser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ewrapper_rx_deser.sv
// rtl/ewrapper_rx_deser.sv - eLink DDR receive deserializer with bit-slip word alignment
// Per-lane 2*RATIO-bit history; words are cut at a slip offset behind the newest bit.
module ewrapper_rx_deser #(
  parameter int LANES  = 9,
  parameter int RATIO  = 8,
  parameter int INVERT = 0
) (
  input  logic                       CLK_IN,
  input  logic                       IO_RESET,
  input  logic [LANES-1:0]           DATA_EVEN,
  input  logic [LANES-1:0]           DATA_ODD,
  input  logic                       ENABLE,
  input  logic                       BITSLIP,
  output logic [LANES*RATIO-1:0]     DATA_OUT,
  output logic                       DATA_OUT_VALID,
  output logic                       BITSLIP_BUSY,
  output logic [$clog2(RATIO)-1:0]   SLIP_OFS
);
  localparam int   OW  = $clog2(RATIO);
  localparam int   CW  = $clog2(RATIO/2);
  localparam int   HW  = 2*RATIO;
  localparam logic INV = (INVERT != 0);

  logic [LANES-1:0][HW-1:0]  hist_q, hist_d;
  logic [LANES*RATIO-1:0]    data_q, data_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [OW-1:0]             ofs_q, ofs_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      seen_q, seen_d;

  logic       emit;
  logic       accept;
  logic [OW:0] base;

  assign emit   = ENABLE && (cnt_q == CW'(RATIO/2-1));
  assign accept = BITSLIP && !busy_q;
  assign base   = {1'b0, ofs_q};

  always_comb begin
    hist_d  = hist_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ofs_d   = ofs_q;
    valid_d = emit;
    busy_d  = busy_q;
    seen_d  = seen_q;
    if (ENABLE) begin
      for (int l = 0; l < LANES; l++) begin
        hist_d[l] = {hist_q[l][HW-3:0], DATA_EVEN[l] ^ INV, DATA_ODD[l] ^ INV};
      end
      cnt_d = emit ? '0 : cnt_q + 1'b1;
    end
    // The word uses the history including this edge's pair and the offset in force before any slip.
    if (emit) begin
      for (int l = 0; l < LANES; l++) begin
        data_d[l*RATIO +: RATIO] = hist_d[l][base +: RATIO];
      end
    end
    if (accept) begin
      ofs_d  = (ofs_q == OW'(RATIO-1)) ? '0 : ofs_q + 1'b1;
      busy_d = 1'b1;
      seen_d = 1'b0;
    end else if (busy_q) begin
      // Hold busy through the cycle that follows the first strobe seen while busy.
      if (seen_q) begin
        busy_d = 1'b0;
        seen_d = 1'b0;
      end else if (valid_q) begin
        seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (IO_RESET) begin
      hist_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      ofs_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ofs_q   <= ofs_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      seen_q  <= seen_d;
    end
  end

  assign DATA_OUT       = data_q;
  assign DATA_OUT_VALID = valid_q;
  assign BITSLIP_BUSY   = busy_q;
  assign SLIP_OFS       = ofs_q;
endmodule

// File: tb/tb_ewrapper_rx_deser.sv
// tb/tb_ewrapper_rx_deser.sv - randomized and directed bench for ewrapper_rx_deser
module tb_ewrapper_rx_deser;
  localparam int LANES = 9;
  localparam int RATIO = 8;
  localparam int HALF  = RATIO/2;
  localparam int DW    = LANES*RATIO;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             en  = 1'b0;
  logic             bs  = 1'b0;
  logic [LANES-1:0] ev  = '0;
  logic [LANES-1:0] od  = '0;

  logic [DW-1:0] dout, dout_i;
  logic          v, v_i, b, b_i;
  logic [2:0]    ofs, ofs_i;

  ewrapper_rx_deser #(.LANES(LANES), .RATIO(RATIO), .INVERT(0)) dut (
    .CLK_IN(clk), .IO_RESET(rst), .DATA_EVEN(ev), .DATA_ODD(od), .ENABLE(en), .BITSLIP(bs),
    .DATA_OUT(dout), .DATA_OUT_VALID(v), .BITSLIP_BUSY(b), .SLIP_OFS(ofs)
  );

  ewrapper_rx_deser #(.LANES(LANES), .RATIO(RATIO), .INVERT(1)) dut_inv (
    .CLK_IN(clk), .IO_RESET(rst), .DATA_EVEN(ev), .DATA_ODD(od), .ENABLE(en), .BITSLIP(bs),
    .DATA_OUT(dout_i), .DATA_OUT_VALID(v_i), .BITSLIP_BUSY(b_i), .SLIP_OFS(ofs_i)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: raw received pairs since reset; a word is read straight from the bit stream.
  logic [LANES-1:0] ev_hist[$];
  logic [LANES-1:0] od_hist[$];
  int          k = 0;
  int          exp_ofs = 0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] exp_data_inv = '0;
  int          busy_end = 0;
  bit          busy_end_set = 1'b0;
  bit          chk = 1'b0;

  bit pe[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit po[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [DW-1:0] model_word(input int o, input bit inv);
    logic [DW-1:0] w;
    int n;
    int p;
    logic bt;
    w = '0;
    n = 2 * ev_hist.size();
    for (int l = 0; l < LANES; l++) begin
      for (int bi = 0; bi < RATIO; bi++) begin
        p = n - 1 - o - bi;
        if (p < 0) bt = 1'b0;
        else bt = ((p % 2 == 0) ? ev_hist[p/2][l] : od_hist[p/2][l]) ^ inv;
        w[l*RATIO + bi] = bt;
      end
    end
    return w;
  endfunction

  task automatic step(input logic r, input logic e, input logic s, input bit use_pat);
    logic [DW-1:0] nx_data, nx_inv;
    logic nx_valid, nx_busy, acc;
    int nx_ofs;
    ev = LANES'($urandom);
    od = LANES'($urandom);
    if (use_pat) begin
      ev[0] = pe[ev_hist.size() % 4];
      od[0] = po[ev_hist.size() % 4];
    end
    rst = r; en = e; bs = s;
    if (exp_busy && exp_valid && !busy_end_set) begin
      busy_end = k + 1;
      busy_end_set = 1'b1;
    end
    if (r) begin
      ev_hist.delete();
      od_hist.delete();
      nx_data = '0; nx_inv = '0; nx_valid = 1'b0; nx_busy = 1'b0; nx_ofs = 0;
      busy_end_set = 1'b0;
    end else begin
      acc = s && !exp_busy;
      nx_valid = 1'b0;
      nx_data = exp_data;
      nx_inv = exp_data_inv;
      if (e) begin
        ev_hist.push_back(ev);
        od_hist.push_back(od);
        if (ev_hist.size() % HALF == 0) begin
          nx_valid = 1'b1;
          nx_data = model_word(exp_ofs, 1'b0);
          nx_inv = model_word(exp_ofs, 1'b1);
        end
      end
      nx_ofs = acc ? (exp_ofs + 1) % RATIO : exp_ofs;
      nx_busy = acc || (exp_busy && !(busy_end_set && k >= busy_end));
      if (acc) busy_end_set = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_data = nx_data; exp_data_inv = nx_inv; exp_valid = nx_valid;
    exp_busy = nx_busy; exp_ofs = nx_ofs;
    k++;
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("data", dout, exp_data);
      check("valid", DW'(v), DW'(exp_valid));
      check("busy", DW'(b), DW'(exp_busy));
      check("ofs", DW'(ofs), DW'(exp_ofs));
      check("data_inv", dout_i, exp_data_inv);
      check("valid_inv", DW'(v_i), DW'(exp_valid));
      check("busy_inv", DW'(b_i), DW'(exp_busy));
      check("ofs_inv", DW'(ofs_i), DW'(exp_ofs));
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (b && n < 20) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    check(name, DW'(b), DW'(0));
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (!v && n < 20) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      n++;
    end
    check(name, DW'(v), DW'(1));
  endtask

  initial begin
    int ns;
    int g;
    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_data", dout, '0);
    check("rst_ofs", DW'(ofs), DW'(0));

    // Plain pattern: 0xB2 every 4 cycles, 0x4D inverted
    ns = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (v) begin
        ns++;
        check("word_b2", DW'(dout[7:0]), DW'(8'hB2));
        check("word_4d", DW'(dout_i[7:0]), DW'(8'h4D));
      end
    end
    check("cadence", DW'(ns), DW'(4));

    // One slip
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("slip_ofs1", DW'(ofs), DW'(1));
    check("slip_busy", DW'(b), DW'(1));
    ns = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (v) begin
        ns++;
        check("word_59", DW'(dout[7:0]), DW'(8'h59));
      end
    end
    check("slip_cadence", DW'(ns), DW'(3));

    // Back-to-back slips: second is ignored; then wrap after eight
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    check("dbl_ofs", DW'(ofs), DW'(1));
    check("dbl_busy", DW'(b), DW'(1));
    for (int i = 0; i < 7; i++) begin
      wait_idle("idle_timeout");
      step(1'b0, 1'b1, 1'b1, 1'b1);
    end
    wait_idle("idle_timeout");
    check("wrap_ofs", DW'(ofs), DW'(0));
    wait_strobe("strobe_timeout");
    check("wrap_b2", DW'(dout[7:0]), DW'(8'hB2));

    // ENABLE gap mid-word
    step(1'b0, 1'b1, 1'b0, 1'b1);
    g = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      g++;
    end
    do begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      g++;
    end while (!v && g < 20);
    check("gap_len", DW'(g), DW'(7));
    check("gap_b2", DW'(dout[7:0]), DW'(8'hB2));

    // Reset at cnt=2 with a pending slip
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("mid_rst_data", dout, '0);
    check("mid_rst_valid", DW'(v), DW'(0));
    check("mid_rst_busy", DW'(b), DW'(0));
    check("mid_rst_ofs", DW'(ofs), DW'(0));
    g = 0;
    do begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      g++;
    end while (!v && g < 20);
    check("rst_first_strobe", DW'(g), DW'(4));
    check("rst_b2", DW'(dout[7:0]), DW'(8'hB2));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) == 0), ($urandom_range(9) < 8), ($urandom_range(9) == 0), 1'b0);
    end

    @(posedge clk);
    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
